// File: rtl/imem_fetch.sv
// Instruction memory with a one-deep registered fetch response (valid/ready, flush, program load).
// Define IMEM_FETCH_ERR_CHECK_EN to flag misaligned or out-of-range fetches; otherwise addresses wrap.
module imem_fetch #(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DEPTH     = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter logic [31:0]          ERR_INSTR = 32'h0000_0013,
  localparam int unsigned         IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [31:0]       ld_data
);

`ifdef IMEM_FETCH_ERR_CHECK_EN
  localparam bit ERR_CHECK = 1'b1;
`else
  localparam bit ERR_CHECK = 1'b0;
`endif

  typedef enum logic {EMPTY, FULL} state_t;

  logic [31:0] im [0:DEPTH-1];

  state_t              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   offset;
  logic [ADDR_W-1:0]   word_full;
  logic [IDX_W-1:0]    idx;
  logic                bad_addr;
  logic                accept;

  assign offset    = req_addr - BASE_ADDR;
  assign word_full = offset >> 2;
  assign idx       = word_full[IDX_W-1:0];
  // Checking is gated by a constant so the default build simply wraps the index.
  assign bad_addr  = ERR_CHECK && ((offset[1:0] != 2'b00) ||
                                   (word_full[ADDR_W-1:IDX_W] != '0));

  assign rsp_valid = (state_q == FULL);
  assign req_ready = (!rsp_valid || rsp_ready) && !flush;
  assign accept    = req_valid && req_ready;
  assign rsp_instr = instr_q;
  assign rsp_pc    = pc_q;
  assign rsp_err   = err_q;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    err_d   = err_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
      instr_d = bad_addr ? ERR_INSTR : im[idx];
      pc_d    = req_addr;
      err_d   = bad_addr;
    end else if (rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the memory array has no reset; contents survive rst_n and map onto plain RAM.
  // The fetch above samples im before this write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (ld_en) im[ld_addr] <= ld_data;
  end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-003 Parameter DEPTH, default 32, SHALL set the number of 32-bit words (power of two, >=2).
REQ-004 Parameter BASE_ADDR, default 0, SHALL set the byte address of word 0.
REQ-005 Parameter ERR_INSTR, default 32'h00000013 (NOP), SHALL set the instruction returned on an error response.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  1  fetch request present.
REQ-009 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-010 req_addr  in  ADDR_W  fetch byte address (PC).
REQ-011 flush  in  1  discards any held response (branch redirect).
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  consumer accepts response.
REQ-014 rsp_instr  out  32  fetched instruction.
REQ-015 rsp_pc  out  ADDR_W  address of the fetched instruction.
REQ-016 rsp_err  out  1  misaligned or out-of-range fetch.
REQ-017 ld_en  in  1  program-load write strobe.
REQ-018 ld_addr  in  clog2(DEPTH)  program-load word index.
REQ-019 ld_data  in  32  program-load word.

Function
REQ-020 Storage SHALL be an unreset array IM[0:DEPTH-1] of 32-bit words, writable hierarchically by a bench.
REQ-021 Word index SHALL be (req_addr - BASE_ADDR) >> 2, computed modulo 2^ADDR_W.
REQ-022 State machine: EMPTY (rsp_valid=0), FULL (rsp_valid=1); one response register.
REQ-023 req_ready SHALL be (!rsp_valid || rsp_ready) && !flush.
REQ-024 An accepted request SHALL present rsp_valid, rsp_instr and rsp_pc=req_addr on the next rising edge (latency 1).
REQ-025 EMPTY->FULL on accept; FULL->EMPTY on rsp_ready without accept; FULL->FULL with new data on rsp_ready and accept in the same cycle (back-to-back, one word per cycle).
REQ-026 While FULL and rsp_ready=0, rsp_instr, rsp_pc, rsp_err SHALL hold stable.
REQ-027 flush SHALL force EMPTY on the next edge regardless of rsp_ready, and no request is accepted in a flush cycle.
REQ-028 ld_en SHALL write ld_data to IM[ld_addr] on the rising edge, independent of fetch state.
REQ-029 A fetch accepted in the same cycle as a load to the same index SHALL return the old word (read-before-write).

Reset
REQ-030 rst_n low SHALL immediately force rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_err=0, state EMPTY.
REQ-031 Reset mid-transaction SHALL drop the held response; IM contents SHALL be unaffected.
REQ-032 req_ready SHALL be 1 during and after reset (flush low).

Configuration
REQ-033 Macro IMEM_FETCH_ERR_CHECK_EN defined: a request with req_addr[1:0]!=0 or index >= DEPTH SHALL respond with rsp_err=1, rsp_instr=ERR_INSTR, same latency and handshake.
REQ-034 Macro undefined: rsp_err SHALL be tied 0, low address bits ignored, index taken modulo DEPTH (wrap-around).

Verification
REQ-035 Preload IM[0]=32'h01234567, IM[1]=32'h01234333; requests 0x0 then 0x4 back-to-back, rsp_ready=1 -> rsp_instr 01234567 then 01234333 on consecutive cycles, rsp_pc 0x0, 0x4.
REQ-036 Request 0x4, hold rsp_ready=0 for 3 cycles -> req_ready=0, rsp_instr stays 01234333; rsp_ready=1 -> state EMPTY next edge.
REQ-037 FULL with rsp_ready=0, assert flush and req_valid -> req_ready=0, rsp_valid=0 next edge, no new response.
REQ-038 ld_en with ld_addr=2, ld_data=32'hDEADBEEF, same-cycle fetch 0x8 (IM[2]=01234569) -> response 01234569; refetch 0x8 -> DEADBEEF.
REQ-039 With IMEM_FETCH_ERR_CHECK_EN, DEPTH=32: fetch 0x2 and 0x80 -> rsp_err=1, rsp_instr=00000013; without macro fetch 0x80 -> contents of IM[0], rsp_err=0.
REQ-040 Assert rst_n low while FULL -> rsp_valid=0 without a clock edge; IM[0] still 01234567 after release.
